// File: rtl/spi_rom_line_fetcher_pkg.sv
// spi_rom_line_fetcher_pkg: shared SPI flash commands and fetcher FSM states
package spi_rom_line_fetcher_pkg;
  localparam logic [7:0] SPI_CMD_READ = 8'h03;
  localparam logic [7:0] SPI_CMD_FAST_READ = 8'h0B;
  typedef enum logic [2:0] {IDLE, PRE, DUMMY, DATA, GAP} state_t;
  function automatic logic is_spi_active(input state_t s);
    return s inside {PRE, DUMMY, DATA};
  endfunction
endpackage

// File: rtl/spi_rom_line_fetcher_bit_engine.sv
// spi_rom_line_fetcher_bit_engine: mode-0 SCLK toggle, MOSI shift-out, MISO shift-in with stall
module spi_rom_line_fetcher_bit_engine (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [31:0] load_word,
  input  logic        run,
  input  logic        stall,
  input  logic        spi_miso,
  output logic        spi_sclk,
  output logic        spi_mosi,
  output logic        fall,
  output logic [7:0]  rx_byte,
  output logic [7:0]  rx_next
);
  logic [31:0] tx_sr;
  assign spi_mosi = tx_sr[31];
  assign fall = run && !stall && spi_sclk;
  assign rx_next = {rx_byte[6:0], spi_miso};
  // each bit is low then high; the high->low edge samples MISO and advances MOSI
  always_ff @(posedge clk)
    if (reset) begin
      spi_sclk <= 1'b0;
      tx_sr <= '0;
      rx_byte <= '0;
    end else if (load) begin
      spi_sclk <= 1'b0;
      tx_sr <= load_word;
    end else if (run && !stall) begin
      spi_sclk <= !spi_sclk;
      if (spi_sclk) begin
        tx_sr <= tx_sr << 1;
        rx_byte <= rx_next;
      end
    end else
      spi_sclk <= 1'b0;
endmodule

// File: rtl/spi_rom_line_fetcher.sv
// spi_rom_line_fetcher: SPI flash READ master streaming bytes to a valid/ready port (SPI_FAST_READ_EN selects 0Bh + dummy byte)
module spi_rom_line_fetcher #(
  parameter int CNT_W = 8,
  parameter int CS_IDLE = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [23:0]      start_addr,
  input  logic [CNT_W-1:0] byte_count,
  output logic             busy,
  output logic             done,
  output logic [7:0]       byte_data,
  output logic             byte_valid,
  input  logic             byte_ready,
  output logic             spi_cs,
  output logic             spi_sclk,
  output logic             spi_mosi,
  input  logic             spi_miso
);
  import spi_rom_line_fetcher_pkg::*;
`ifdef SPI_FAST_READ_EN
  localparam logic [7:0] CMD = SPI_CMD_FAST_READ;
  localparam state_t AFTER_PRE = DUMMY;
`else
  localparam logic [7:0] CMD = SPI_CMD_READ;
  localparam state_t AFTER_PRE = DATA;
`endif
  state_t state, state_n;
  logic [4:0] bit_cnt;
  logic [CNT_W-1:0] byte_left;
  logic [7:0] gap_cnt, rx_byte, rx_next;
  logic pend, fall, accept, phase_end, byte_done, out_free, gap_ok;
  assign accept = state == IDLE && start && byte_count != '0;
  assign phase_end = fall && bit_cnt == 5'd0;
  assign byte_done = phase_end && state == DATA;
  assign out_free = !byte_valid || byte_ready;
  assign gap_ok = !spi_cs && int'(gap_cnt) + 1 >= CS_IDLE && !pend && out_free;
  spi_rom_line_fetcher_bit_engine u_eng (
    .clk(clk),
    .reset(reset),
    .load(accept),
    .load_word({CMD, start_addr}),
    .run(is_spi_active(state)),
    .stall(pend),
    .spi_miso(spi_miso),
    .spi_sclk(spi_sclk),
    .spi_mosi(spi_mosi),
    .fall(fall),
    .rx_byte(rx_byte),
    .rx_next(rx_next)
  );
  // phase sequencing: preamble, optional dummy byte, data bytes, then CS gap
  always_comb begin
    state_n = state;
    if (accept) state_n = PRE;
    else if (state == PRE && phase_end) state_n = AFTER_PRE;
    else if (state == DUMMY && phase_end) state_n = DATA;
    else if (byte_done && byte_left == CNT_W'(1)) state_n = GAP;
    else if (state == GAP && gap_ok) state_n = IDLE;
  end
  // state register
  always_ff @(posedge clk)
    state <= reset ? IDLE : state_n;
  // counters, chip select, handshake and the one-deep output register backed by the shifter
  always_ff @(posedge clk)
    if (reset) begin
      spi_cs <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      bit_cnt <= '0;
      byte_left <= '0;
      gap_cnt <= '0;
      pend <= 1'b0;
      byte_valid <= 1'b0;
      byte_data <= '0;
    end else begin
      spi_cs <= is_spi_active(state_n) || state == DATA;
      busy <= state_n != IDLE;
      done <= (state == IDLE && start && byte_count == '0) || (state == GAP && gap_ok);
      bit_cnt <= accept ? 5'd31 : !fall ? bit_cnt : bit_cnt == 5'd0 ? 5'd7 : bit_cnt - 5'd1;
      byte_left <= accept ? byte_count : byte_done ? byte_left - CNT_W'(1) : byte_left;
      gap_cnt <= state != GAP ? 8'd0 : (!spi_cs && int'(gap_cnt) < CS_IDLE) ? gap_cnt + 8'd1 : gap_cnt;
      pend <= byte_done ? !out_free : pend && !out_free;
      byte_valid <= (byte_done || pend) ? 1'b1 : byte_valid && !byte_ready;
      byte_data <= (byte_done && out_free) ? rx_next : (pend && out_free) ? rx_byte : byte_data;
    end
endmodule

// File: tb/tb_spi_rom_line_fetcher.sv
// tb_spi_rom_line_fetcher: flash model plus directed and random transactions checked against expected byte streams and timing
module tb_spi_rom_line_fetcher;
`ifdef SPI_FAST_READ_EN
  localparam logic [7:0] CMD = 8'h0B;
  localparam int PRE_BITS = 40;
`else
  localparam logic [7:0] CMD = 8'h03;
  localparam int PRE_BITS = 32;
`endif
  localparam int FIRST = 2 * PRE_BITS + 16;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0, byte_ready = 1'b1;
  logic [23:0] start_addr = '0;
  logic [7:0] byte_count = '0;
  logic busy, done, byte_valid, spi_cs, spi_sclk, spi_mosi;
  logic [7:0] byte_data;
  logic spi_miso = 1'b0;
  int n_chk = 0, n_fail = 0, cyc = 0;

  spi_rom_line_fetcher dut (
    .clk(clk), .reset(reset), .start(start), .start_addr(start_addr),
    .byte_count(byte_count), .busy(busy), .done(done), .byte_data(byte_data),
    .byte_valid(byte_valid), .byte_ready(byte_ready), .spi_cs(spi_cs),
    .spi_sclk(spi_sclk), .spi_mosi(spi_mosi), .spi_miso(spi_miso)
  );

  always #5 clk = ~clk;

`define CHK(tag, obs, exp) begin n_chk++; assert ((obs) === (exp)) else begin n_fail++; $error("FAIL %s: observed %0h expected %0h", tag, (obs), (exp)); end end

  function automatic logic [7:0] flash_byte(input logic [23:0] a);
    logic [23:0] h;
    if (a == 24'h000120) return 8'hA5;
    if (a == 24'h000121) return 8'h3C;
    h = a * 24'd40503;
    return h[15:8] ^ a[7:0];
  endfunction

  // flash: latch command/address on SCLK rise, present data bits during each high phase
  int k = 0;
  logic [31:0] mosi_word = '0;
  logic dummy_or = 1'b0, prev_sclk = 1'b0;
  always @(negedge clk) begin
    if (!spi_cs) k = 0;
    else if (spi_sclk && !prev_sclk) begin
      if (k == 0) dummy_or = 1'b0;
      if (k < 32) mosi_word = {mosi_word[30:0], spi_mosi};
      else if (k < PRE_BITS) dummy_or = dummy_or | spi_mosi;
      if (k >= PRE_BITS) begin
        logic [7:0] b;
        b = flash_byte(mosi_word[23:0] + 24'((k - PRE_BITS) / 8));
        spi_miso = b[7 - (k - PRE_BITS) % 8];
      end
      k++;
    end
    prev_sclk = spi_sclk;
  end

  task automatic tick;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // mode 0: ready held high, 1: ready low 40 cycles from first valid, 2: random ready and stray starts
  task automatic txn(input logic [23:0] addr, input int cnt, input int mode, input bit timing);
    logic [7:0] exp_q[$], got_q[$];
    int got_cyc[$];
    int n, first_v = -1, cs_low = -1, done_n = 0, stall_hi = 0, data_chg = 0, busy_bad = 0;
    logic done_busy = 1'b1;
    for (int i = 0; i < cnt; i++) exp_q.push_back(flash_byte(addr + 24'(i)));
    byte_ready = (mode != 1);
    start_addr = addr;
    byte_count = 8'(cnt);
    start = 1'b1;
    tick();
    n = cyc;
    start = 1'b0;
    start_addr = 24'($urandom);
    byte_count = 8'($urandom);
    if (cnt == 0) begin
      `CHK("zero_done", done, 1'b1)
      `CHK("zero_busy", busy, 1'b0)
      `CHK("zero_cs", spi_cs, 1'b0)
      tick();
      `CHK("zero_done_pulse", done, 1'b0)
      `CHK("zero_cs_after", spi_cs, 1'b0)
      return;
    end
    `CHK("accept_cs", spi_cs, 1'b1)
    `CHK("accept_sclk", spi_sclk, 1'b0)
    `CHK("accept_mosi", spi_mosi, CMD[7])
    `CHK("accept_busy", busy, 1'b1)
    for (int t = 0; t < 400 + cnt * 64 && done_n == 0; t++) begin
      if (byte_valid && first_v < 0) first_v = cyc;
      if (mode == 1 && first_v >= 0) byte_ready = (cyc >= first_v + 40);
      if (mode == 2) byte_ready = 1'($urandom_range(0, 1));
      if (mode == 1 && first_v >= 0 && cyc < first_v + 40) begin
        if (cyc >= first_v + 16 && spi_sclk) stall_hi++;
        if (!byte_valid || byte_data !== exp_q[0]) data_chg++;
      end
      if (byte_valid && byte_ready) begin
        got_q.push_back(byte_data);
        got_cyc.push_back(cyc);
      end
      if (!spi_cs && cs_low < 0) cs_low = cyc;
      if (done) begin
        done_n++;
        done_busy = busy;
      end else if (!busy) busy_bad++;
      start = (mode == 2 && !done) ? 1'($urandom_range(0, 1)) : 1'b0;
      byte_count = 8'($urandom);
      tick();
    end
    start = 1'b0;
    `CHK("done_seen", done_n, 1)
    `CHK("busy_low_at_done", done_busy, 1'b0)
    `CHK("busy_held", busy_bad, 0)
    tick();
    `CHK("done_one_pulse", done, 1'b0)
    `CHK("byte_total", got_q.size(), cnt)
    `CHK("byte_stream", got_q == exp_q, 1'b1)
    `CHK("mosi_cmd_addr", mosi_word, {CMD, addr})
`ifdef SPI_FAST_READ_EN
    `CHK("mosi_dummy_zero", dummy_or, 1'b0)
`endif
    if (timing) begin
      `CHK("first_valid_cycle", first_v, n + FIRST)
      if (mode == 0) begin
        for (int i = 0; i < got_cyc.size(); i++) `CHK("byte_cycle", got_cyc[i], n + FIRST + 16 * i)
        `CHK("cs_drop_cycle", cs_low, n + FIRST + 16 * (cnt - 1) + 1)
      end
      if (mode == 1) begin
        `CHK("sclk_frozen_in_stall", stall_hi, 0)
        `CHK("data_stable_in_stall", data_chg, 0)
      end
    end
  endtask

  initial begin
    int act, w;
    reset = 1'b1;
    repeat (3) tick();
    `CHK("reset_outputs", {spi_cs, spi_sclk, spi_mosi, busy, done, byte_valid, byte_data}, 14'h0)
    reset = 1'b0;
    act = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (spi_sclk || spi_cs || busy) act++;
    end
    `CHK("idle_quiet", act, 0)

    txn(24'h000120, 2, 0, 1'b1);
    txn(24'($urandom), 3, 1, 1'b1);
    txn(24'($urandom), 0, 0, 1'b0);

    byte_ready = 1'b0;
    start_addr = 24'($urandom);
    byte_count = 8'd5;
    start = 1'b1;
    tick();
    start = 1'b0;
    w = 0;
    while (!byte_valid && w < 200) begin
      tick();
      w++;
    end
    `CHK("mid_data_reached", byte_valid, 1'b1)
    repeat (5) tick();
    reset = 1'b1;
    tick();
    `CHK("abort_cs", spi_cs, 1'b0)
    `CHK("abort_valid", byte_valid, 1'b0)
    `CHK("abort_busy", busy, 1'b0)
    `CHK("abort_sclk", spi_sclk, 1'b0)
    `CHK("abort_data", byte_data, 8'h00)
    reset = 1'b0;
    tick();
    txn(24'($urandom), 1, 0, 1'b1);

    txn(24'hFFFFFF, 2, 0, 1'b1);
    txn(24'($urandom), 255, 0, 1'b1);
    for (int i = 0; i < 6; i++) txn(24'($urandom), $urandom_range(1, 6), 2, 1'b0);
    txn(24'($urandom), 4, 1, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
